// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage decode fields and operand-mux/stall controls exchanged with the forwarding unit.
interface fwd_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  stall_i;
    logic                  flush_i;
    logic                  id_valid_i;
    logic [REG_ADDR_W-1:0] id_rs_i;
    logic [REG_ADDR_W-1:0] id_rt_i;
    logic                  id_use_rs_i;
    logic                  id_use_rt_i;
    logic [REG_ADDR_W-1:0] id_dst_i;
    logic                  id_regwrite_i;
    logic                  id_memread_i;
    logic                  id_srl_i;
    logic [1:0]            fwd_a_sel_o;
    logic [1:0]            fwd_b_sel_o;
    logic                  srl_o;
    logic                  ex_valid_o;
    logic                  hazard_stall_o;
    logic [CNT_W-1:0]      stall_count_o;

    modport master (
        output stall_i, flush_i, id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_dst_i, id_regwrite_i, id_memread_i, id_srl_i,
        input  fwd_a_sel_o, fwd_b_sel_o, srl_o, ex_valid_o, hazard_stall_o, stall_count_o
    );

    modport slave (
        input  stall_i, flush_i, id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_dst_i, id_regwrite_i, id_memread_i, id_srl_i,
        output fwd_a_sel_o, fwd_b_sel_o, srl_o, ex_valid_o, hazard_stall_o, stall_count_o
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: shadows the EX/MEM destination tags and
// registers the ALU operand selects at the ID/EX boundary.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input logic              clk_i,
    input logic              rst_i,
    fwd_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        SEL_RF     = 2'b00,
        SEL_EX_MEM = 2'b01,
        SEL_MEM_WB = 2'b10
    } fwd_sel_e;

    logic [REG_ADDR_W-1:0] ex_dst_q, ex_dst_d, mem_dst_q, mem_dst_d;
    logic                  ex_rw_q, ex_rw_d, ex_mr_q, ex_mr_d, mem_rw_q, mem_rw_d;
    fwd_sel_e              fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic                  srl_q, srl_d, ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic                  bubble, load_use, hazard;
    fwd_sel_e              sel_a, sel_b;

    function automatic fwd_sel_e match_src(
        input logic                  use_s,
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] ex_dst,
        input logic                  ex_rw,
        input logic                  ex_mr,
        input logic [REG_ADDR_W-1:0] mem_dst,
        input logic                  mem_rw
    );
        fwd_sel_e sel;
        sel = SEL_RF;
        // A load in EX has no data yet, so only non-load EX results are forwardable.
        if (use_s && src != '0) begin
            if (src == ex_dst && ex_rw && !ex_mr) sel = SEL_EX_MEM;
            else if (src == mem_dst && mem_rw)    sel = SEL_MEM_WB;
        end
        return sel;
    endfunction

    assign bubble   = !bus.id_valid_i || bus.flush_i;
    assign load_use = ex_mr_q && ex_rw_q && (ex_dst_q != '0) &&
                      ((bus.id_use_rs_i && bus.id_rs_i == ex_dst_q) ||
                       (bus.id_use_rt_i && bus.id_rt_i == ex_dst_q));
    assign hazard   = !bubble && !bus.stall_i && load_use;

    assign sel_a = bus.id_srl_i ? SEL_RF
                 : match_src(bus.id_use_rs_i, bus.id_rs_i, ex_dst_q, ex_rw_q, ex_mr_q,
                             mem_dst_q, mem_rw_q);
    assign sel_b = match_src(bus.id_use_rt_i, bus.id_rt_i, ex_dst_q, ex_rw_q, ex_mr_q,
                             mem_dst_q, mem_rw_q);

    always_comb begin
        // NOTE: every _d starts from its hold value so no branch can leave a latch behind.
        ex_dst_d    = ex_dst_q;
        ex_rw_d     = ex_rw_q;
        ex_mr_d     = ex_mr_q;
        mem_dst_d   = mem_dst_q;
        mem_rw_d    = mem_rw_q;
        fwd_a_d     = fwd_a_q;
        fwd_b_d     = fwd_b_q;
        srl_d       = srl_q;
        ex_valid_d  = ex_valid_q;
        stall_cnt_d = stall_cnt_q;
        if (!bus.stall_i) begin
            mem_dst_d = ex_dst_q;
            mem_rw_d  = ex_rw_q;
            if (bubble || hazard) begin
                ex_dst_d   = '0;
                ex_rw_d    = 1'b0;
                ex_mr_d    = 1'b0;
                fwd_a_d    = SEL_RF;
                fwd_b_d    = SEL_RF;
                srl_d      = 1'b0;
                ex_valid_d = 1'b0;
            end else begin
                ex_dst_d   = bus.id_dst_i;
                ex_rw_d    = bus.id_regwrite_i;
                ex_mr_d    = bus.id_memread_i;
                fwd_a_d    = sel_a;
                fwd_b_d    = sel_b;
                srl_d      = bus.id_srl_i;
                ex_valid_d = 1'b1;
            end
            if (hazard && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_dst_q    <= '0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            mem_dst_q   <= '0;
            mem_rw_q    <= 1'b0;
            fwd_a_q     <= SEL_RF;
            fwd_b_q     <= SEL_RF;
            srl_q       <= 1'b0;
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_dst_q    <= ex_dst_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            mem_dst_q   <= mem_dst_d;
            mem_rw_q    <= mem_rw_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            srl_q       <= srl_d;
            ex_valid_q  <= ex_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.fwd_a_sel_o    = fwd_a_q;
    assign bus.fwd_b_sel_o    = fwd_b_q;
    assign bus.srl_o          = srl_q;
    assign bus.ex_valid_o     = ex_valid_q;
    assign bus.hazard_stall_o = hazard;
    assign bus.stall_count_o  = stall_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: each ID instruction pushes its expected ID/EX
// controls, popped and compared once the clock edge has registered them.
module tb_fwd_hazard_ctrl;
    localparam int RW = 5;
    localparam int CW = 16;

    logic clk_i = 1'b0;
    logic rst_i;

    fwd_hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

    fwd_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          v;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic          urs;
        logic          urt;
        logic [RW-1:0] dst;
        logic          rw;
        logic          mr;
        logic          srl;
        logic          fl;
        logic          st;
    } ins_t;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic       srl;
        logic       v;
        logic       hz;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic ins_t nop();
        ins_t i;
        i = '{v: 1'b0, rs: '0, rt: '0, urs: 1'b0, urt: 1'b0, dst: '0,
              rw: 1'b0, mr: 1'b0, srl: 1'b0, fl: 1'b0, st: 1'b0};
        return i;
    endfunction

    function automatic ins_t alu(input int rs, input int rt, input int dst);
        ins_t i;
        i     = nop();
        i.v   = 1'b1;
        i.rs  = RW'(rs);
        i.rt  = RW'(rt);
        i.urs = 1'b1;
        i.urt = 1'b1;
        i.dst = RW'(dst);
        i.rw  = 1'b1;
        return i;
    endfunction

    function automatic ins_t lw(input int base, input int dst);
        ins_t i;
        i     = nop();
        i.v   = 1'b1;
        i.rs  = RW'(base);
        i.urs = 1'b1;
        i.dst = RW'(dst);
        i.rw  = 1'b1;
        i.mr  = 1'b1;
        return i;
    endfunction

    function automatic exp_t ex(input logic [1:0] a, input logic [1:0] b,
                                input logic srl, input logic v, input logic hz);
        exp_t e;
        e = '{a: a, b: b, srl: srl, v: v, hz: hz};
        return e;
    endfunction

    task automatic drive(input ins_t in);
        bus.id_valid_i    = in.v;
        bus.id_rs_i       = in.rs;
        bus.id_rt_i       = in.rt;
        bus.id_use_rs_i   = in.urs;
        bus.id_use_rt_i   = in.urt;
        bus.id_dst_i      = in.dst;
        bus.id_regwrite_i = in.rw;
        bus.id_memread_i  = in.mr;
        bus.id_srl_i      = in.srl;
        bus.flush_i       = in.fl;
        bus.stall_i       = in.st;
    endtask

    // Drive one ID cycle, capture the combinational stall, clock it and score the result.
    task automatic step(input string tag, input ins_t in, input exp_t e);
        exp_t got, want;
        logic hz;
        drive(in);
        #1;
        hz = bus.hazard_stall_o;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        want = exp_q.pop_front();
        got  = '{a: bus.fwd_a_sel_o, b: bus.fwd_b_sel_o, srl: bus.srl_o,
                 v: bus.ex_valid_o, hz: hz};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got a=%b b=%b srl=%b v=%b stall=%b, want a=%b b=%b srl=%b v=%b stall=%b",
                     tag, got.a, got.b, got.srl, got.v, got.hz,
                     want.a, want.b, want.srl, want.v, want.hz);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive(nop());
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(alu(1, 2, 3));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        n_cmp++;
        if ({bus.fwd_a_sel_o, bus.fwd_b_sel_o, bus.srl_o, bus.ex_valid_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, want 000000",
                     {bus.fwd_a_sel_o, bus.fwd_b_sel_o, bus.srl_o, bus.ex_valid_o});
        end
        n_cmp++;
        if (bus.stall_count_o !== '0) begin
            n_err++;
            $display("FAIL reset_count: got %h, want 0000", bus.stall_count_o);
        end
        n_cmp++;
        if (bus.hazard_stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_stall: got %b, want 0", bus.hazard_stall_o);
        end
    endtask

    task automatic test_forward();
        ins_t i;
        do_reset();
        step("fwd_first",    alu(1, 2, 3), ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        step("fwd_ex_a",     alu(3, 1, 7), ex(2'b01, 2'b00, 1'b0, 1'b1, 1'b0));
        step("fwd_mem_b",    alu(2, 3, 8), ex(2'b00, 2'b10, 1'b0, 1'b1, 1'b0));
        step("fwd_ex_mem",   alu(8, 7, 9), ex(2'b01, 2'b10, 1'b0, 1'b1, 1'b0));
        step("fwd_self",     alu(9, 2, 9), ex(2'b01, 2'b00, 1'b0, 1'b1, 1'b0));
        step("fwd_priority", alu(9, 9, 4), ex(2'b01, 2'b01, 1'b0, 1'b1, 1'b0));
        i     = alu(9, 4, 4);
        i.urs = 1'b0;
        i.urt = 1'b0;
        step("fwd_unused",   i,            ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic test_load_use();
        do_reset();
        step("lu_load",   lw(1, 4),     ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        step("lu_stall",  alu(4, 2, 5), ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
        n_cmp++;
        if (bus.stall_count_o !== 16'd1) begin
            n_err++;
            $display("FAIL lu_count: got %0d, want 1", bus.stall_count_o);
        end
        step("lu_resume", alu(4, 2, 5), ex(2'b10, 2'b00, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic test_zero_reg();
        do_reset();
        step("zero_writer", alu(1, 2, 0), ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        step("zero_reader", alu(0, 0, 6), ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        step("zero_load",   lw(1, 0),     ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        step("zero_nostal", alu(0, 0, 7), ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        n_cmp++;
        if (bus.stall_count_o !== 16'd0) begin
            n_err++;
            $display("FAIL zero_count: got %0d, want 0", bus.stall_count_o);
        end
    endtask

    task automatic test_srl();
        ins_t i;
        do_reset();
        step("srl_writer", alu(1, 2, 5), ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        i     = alu(5, 5, 6);
        i.srl = 1'b1;
        step("srl_force",  i,            ex(2'b00, 2'b01, 1'b1, 1'b1, 1'b0));
        step("srl_clear",  alu(6, 5, 7), ex(2'b01, 2'b10, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic test_flush_stall();
        ins_t i;
        do_reset();
        step("fs_load",   lw(1, 6),     ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        i    = alu(6, 2, 7);
        i.st = 1'b1;
        step("fs_hold",   i,            ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        i    = alu(6, 2, 7);
        i.fl = 1'b1;
        step("fs_flush",  i,            ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        step("fs_after",  alu(6, 2, 7), ex(2'b10, 2'b00, 1'b0, 1'b1, 1'b0));
        i    = alu(7, 7, 8);
        i.v  = 1'b0;
        step("fs_invalid", i,           ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        n_cmp++;
        if (bus.stall_count_o !== 16'd0) begin
            n_err++;
            $display("FAIL fs_count: got %0d, want 0", bus.stall_count_o);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        step("sat_load1",  lw(1, 4),     ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        step("sat_stall1", alu(4, 2, 5), ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
        n_cmp++;
        if (bus.stall_count_o !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_reach: got %h, want ffff", bus.stall_count_o);
        end
        step("sat_resume", alu(4, 2, 5), ex(2'b10, 2'b00, 1'b0, 1'b1, 1'b0));
        step("sat_load2",  lw(1, 4),     ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        step("sat_stall2", alu(4, 2, 5), ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
        n_cmp++;
        if (bus.stall_count_o !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_hold: got %h, want ffff", bus.stall_count_o);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        step("rms_load", lw(1, 4), ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        drive(alu(4, 2, 5));
        #1;
        n_cmp++;
        if (bus.hazard_stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL rms_pre: got %b, want 1", bus.hazard_stall_o);
        end
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        n_cmp++;
        if ({bus.fwd_a_sel_o, bus.fwd_b_sel_o, bus.srl_o, bus.ex_valid_o, bus.hazard_stall_o}
            !== 7'b0) begin
            n_err++;
            $display("FAIL rms_outputs: got %b, want 0000000",
                     {bus.fwd_a_sel_o, bus.fwd_b_sel_o, bus.srl_o, bus.ex_valid_o,
                      bus.hazard_stall_o});
        end
        n_cmp++;
        if (bus.stall_count_o !== 16'd0) begin
            n_err++;
            $display("FAIL rms_count: got %0d, want 0", bus.stall_count_o);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_zero_reg();
        test_srl();
        test_flush_stall();
        test_saturate();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
